alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one parameter, RR_RESET_PRIO (default 0): the requester index holding priority after reset; legal values are 0 or 1.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-003 Ports SHALL be exactly:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  4  requester 0 ALU opcode
- req0_a  in  32  requester 0 operand A
- req0_b  in  32  requester 0 operand B
- req1_valid / req1_ready / req1_op / req1_a / req1_b: as requester 0, for requester 1
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  1  index of the requester that owns the response
- rsp_result  out  32  ALU result
- rsp_zero  out  1  result == 0

Function
REQ-004 The block SHALL share one alu instance between two requesters using valid/ready handshakes; a transfer occurs on any edge where valid and ready are both high.
REQ-005 The FSM SHALL have two states:
- IDLE: waiting for a request.
- RESP: holding a response.
REQ-006 In IDLE, at most one reqN_ready SHALL be high, driven combinationally from the valid inputs and the priority pointer:
- Only one valid high: that requester is granted.
- Both valid high: the requester named by the priority pointer is granted.
REQ-007 On a transfer in IDLE, the block SHALL:
- register op, a, b and the granted index;
- set the priority pointer to the other requester;
- move to RESP.
REQ-008 In RESP, both reqN_ready SHALL be 0, and rsp_valid SHALL be 1.
REQ-009 rsp_result and rsp_zero SHALL be the alu outputs computed from the registered operands, giving 1-cycle latency from acceptance to rsp_valid.
REQ-010 rsp_valid, rsp_id, rsp_result and rsp_zero SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-011 In RESP with rsp_ready=1, the FSM SHALL return to IDLE; the next acceptance is possible one cycle later, so peak throughput is one operation per 2 cycles.
REQ-012 reqN_ready SHALL NOT depend combinationally on rsp_ready.
REQ-013 Opcodes SHALL follow alu:
- 0000 AND
- 0001 OR
- 0010 ADD, modulo 2^32
- 0110 SUB, modulo 2^32
- any other value: result 0 and zero 1, passed through without error.
REQ-014 A requester that drops valid before it is granted SHALL lose nothing and SHALL NOT affect the priority pointer.
REQ-015 rsp_zero SHALL equal (rsp_result == 0) in every cycle where rsp_valid=1.

Reset
REQ-016 When rst=1 at a clock edge, the block SHALL set:
- FSM to IDLE
- rsp_valid to 0
- rsp_id to 0
- operand registers and op register to 0
- priority pointer to RR_RESET_PRIO
REQ-017 While rst=1, both reqN_ready SHALL be 0.
REQ-018 Reset asserted during RESP SHALL discard the pending response with no completion signalled; rsp_valid SHALL be 0 after that edge.

Structure
REQ-019 A shared package alu_pkg SHALL hold:
- the ALU opcode enum (AND, OR, ADD, SUB encodings);
- the arbiter FSM state enum;
- the DATA_W=32 constant.
REQ-020 The block SHALL instantiate the existing alu as its only sub-module and SHALL add no arithmetic of its own.

Verification
REQ-021 Single request: req0 ADD a=5, b=6 -> req0_ready=1 in the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=11, rsp_zero=0.
REQ-022 Simultaneous after reset (RR_RESET_PRIO=0): req0 AND ffffffff/00ff00ff and req1 SUB 5-6 ->
- first response: id 0, result 00ff00ff;
- second response: id 1, result ffffffff.
REQ-023 Backpressure: rsp_ready held 0 for 3 cycles -> response fields stable and both req_ready=0 throughout; completes on the cycle rsp_ready=1.
REQ-024 Invalid op: op 1110, a=5, b=2222 -> rsp_result=0, rsp_zero=1.
REQ-025 Fairness: both valid continuously for 4 transactions -> rsp_id sequence 0,1,0,1; SUB 7fffffff-(-1) -> 80000000.
REQ-026 Reset during RESP -> rsp_valid=0 next cycle; with both requesters valid, the first grant goes to RR_RESET_PRIO.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU and the two-requester ALU arbiter.
// Holds the data width, the ALU opcode encodings and the arbiter FSM states.
package alu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0110
    } alu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu: combinational AND/OR/ADD/SUB unit; unknown opcodes give 0.
// Ports: op (4b opcode), a/b (operands), result, zero (result == 0).
module alu
    import alu_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    always_comb begin
        result = '0;
        unique case (1'b1)
            (op == OP_AND): result = a & b;
            (op == OP_OR):  result = a | b;
            (op == OP_ADD): result = a + b;
            (op == OP_SUB): result = a - b;
            default:        result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one alu between two valid/ready requesters.
// Ports: clk, rst (sync, high), req0/req1 valid/ready/op/a/b, rsp valid/ready/id/result/zero.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int RR_RESET_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero
);

    arb_state_e        state;
    arb_state_e        state_nx;
    logic              prio;
    logic              gnt0;
    logic              gnt1;
    logic              take;
    logic              take_id;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              id_q;

    // Lone requester always wins; on a tie the pointer decides.
    assign gnt0 = req0_valid & (~req1_valid | ~prio);
    assign gnt1 = req1_valid & (~req0_valid |  prio);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        take       = 1'b0;
        take_id    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!rst) begin
                    req0_ready = gnt0;
                    req1_ready = gnt1;
                    take       = gnt0 | gnt1;
                    take_id    = gnt1;
                end
                if (take) state_nx = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Pointer only moves on an actual transfer, so a requester
    // withdrawing before grant leaves the order untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= RR_RESET_PRIO[0];
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            id_q <= 1'b0;
        end else if (take) begin
            prio <= ~take_id;
            op_q <= take_id ? req1_op : req0_op;
            a_q  <= take_id ? req1_a  : req0_a;
            b_q  <= take_id ? req1_b  : req0_b;
            id_q <= take_id;
        end
    end

    assign rsp_id = id_q;

    alu u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (rsp_result),
        .zero   (rsp_zero)
    );

endmodule
